// File: rtl/date_counter.sv
`default_nettype none
// ============================================================================
// Module   : date_counter
// Purpose  : Calendar day/month/year register; advances on tick and
//            commits validated date-set requests using nod from day_rst.
// Revision : 1.0  initial release
// ============================================================================
module date_counter #(
    parameter int unsigned RST_YEAR = 2000,
    parameter int unsigned RST_MON  = 1,
    parameter int unsigned RST_DAY  = 1,
    parameter int unsigned MAX_YEAR = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        set_req,
    input  logic [4:0]  set_day,
    input  logic [3:0]  set_mon,
    input  logic [13:0] set_year,
    input  logic [5:0]  nod,
    output logic [13:0] q_year,
    output logic [3:0]  q_mon,
    output logic [4:0]  day,
    output logic [3:0]  mon,
    output logic [13:0] year,
    output logic        set_ack,
    output logic        set_err,
    output logic        carry_mon,
    output logic        carry_year
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        CHECK = 1'b1
    } state_t;

    localparam logic [13:0] C_MAX_YEAR = 14'(MAX_YEAR);
    localparam logic [13:0] C_RST_YEAR = 14'(RST_YEAR);
    localparam logic [3:0]  C_RST_MON  = 4'(RST_MON);
    localparam logic [4:0]  C_RST_DAY  = 5'(RST_DAY);

    state_t      state_q;
    logic [4:0]  day_q;
    logic [3:0]  mon_q;
    logic [13:0] year_q;
    logic [4:0]  pend_day_q;
    logic [3:0]  pend_mon_q;
    logic [13:0] pend_year_q;
    logic        tick_pend_q;
    logic        set_ack_q;
    logic        set_err_q;
    logic        carry_mon_q;
    logic        carry_year_q;

    logic [4:0]  adv_day_d;
    logic [3:0]  adv_mon_d;
    logic [13:0] adv_year_d;
    logic        adv_cm_d;
    logic        adv_cy_d;
    logic [5:0]  day_inc;
    logic        do_tick;
    logic        pend_valid;

    // day_rst is queried about the pending date while it is being checked
    always_comb begin
        q_mon  = mon_q;
        q_year = year_q;
        if (state_q == CHECK) begin
            q_mon  = pend_mon_q;
            q_year = pend_year_q;
        end
    end

    assign day_inc = {1'b0, day_q} + 6'd1;
    assign do_tick = tick | tick_pend_q;

    always_comb begin
        adv_day_d  = day_inc[4:0];
        adv_mon_d  = mon_q;
        adv_year_d = year_q;
        adv_cm_d   = 1'b0;
        adv_cy_d   = 1'b0;
        if (day_inc >= nod) begin
            adv_day_d = 5'd1;
            adv_cm_d  = 1'b1;
            if (mon_q == 4'd12) begin
                adv_mon_d  = 4'd1;
                adv_cy_d   = 1'b1;
                adv_year_d = (year_q == C_MAX_YEAR) ? 14'd0 : year_q + 14'd1;
            end else begin
                adv_mon_d = mon_q + 4'd1;
            end
        end
    end

    // An out-of-range month leaves nod at its default, so the month test rejects it
    assign pend_valid = (pend_mon_q >= 4'd1) && (pend_mon_q <= 4'd12) &&
                        (pend_day_q != 5'd0) && ({1'b0, pend_day_q} < nod) &&
                        (pend_year_q <= C_MAX_YEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            day_q        <= C_RST_DAY;
            mon_q        <= C_RST_MON;
            year_q       <= C_RST_YEAR;
            pend_day_q   <= 5'd0;
            pend_mon_q   <= 4'd0;
            pend_year_q  <= 14'd0;
            tick_pend_q  <= 1'b0;
            set_ack_q    <= 1'b0;
            set_err_q    <= 1'b0;
            carry_mon_q  <= 1'b0;
            carry_year_q <= 1'b0;
        end else begin
            set_ack_q    <= 1'b0;
            set_err_q    <= 1'b0;
            carry_mon_q  <= 1'b0;
            carry_year_q <= 1'b0;
            if (state_q == RUN) begin
                tick_pend_q <= 1'b0;
                if (do_tick) begin
                    day_q        <= adv_day_d;
                    mon_q        <= adv_mon_d;
                    year_q       <= adv_year_d;
                    carry_mon_q  <= adv_cm_d;
                    carry_year_q <= adv_cy_d;
                end
                if (set_req) begin
                    pend_day_q  <= set_day;
                    pend_mon_q  <= set_mon;
                    pend_year_q <= set_year;
                    state_q     <= CHECK;
                end
            end else begin
                // a tick arriving here is deferred to the first RUN cycle
                tick_pend_q <= tick;
                set_ack_q   <= 1'b1;
                set_err_q   <= ~pend_valid;
                if (pend_valid) begin
                    day_q  <= pend_day_q;
                    mon_q  <= pend_mon_q;
                    year_q <= pend_year_q;
                end
                state_q <= RUN;
            end
        end
    end

    assign day        = day_q;
    assign mon        = mon_q;
    assign year       = year_q;
    assign set_ack    = set_ack_q;
    assign set_err    = set_err_q;
    assign carry_mon  = carry_mon_q;
    assign carry_year = carry_year_q;

endmodule
`default_nettype wire

// File: doc/date_counter.md
Name: date_counter

Overview:
- Calendar register stage directly downstream of the month-length block (`day_rst`).
- Holds the current day, month and year, and advances the date by one day per `tick`.
- Drives the query year/month into `day_rst` and consumes its combinational `nod` (days-in-month + 1) to decide day rollover.
- Also accepts a software/button date-set request, validated against `nod` before commit.

Parameters:
- RST_YEAR, 2000, year value after reset.
- RST_MON, 1, month value after reset (1..12).
- RST_DAY, 1, day value after reset (1..31, must be valid for RST_MON/RST_YEAR).
- MAX_YEAR, 9999, last year; the year after it wraps to 0.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle pulse: advance date by one day.
- set_req  input  1  one-cycle pulse: request load of set_day/set_mon/set_year.
- set_day  input  5  requested day.
- set_mon  input  4  requested month.
- set_year  input  14  requested year.
- nod  input  6  from `day_rst`: days in month q_mon/q_year, plus 1 (32, 31, 30 or 29).
- q_year  output  14  year presented to `day_rst`.
- q_mon  output  4  month presented to `day_rst`.
- day  output  5  current day, registered.
- mon  output  4  current month, registered.
- year  output  14  current year, registered.
- set_ack  output  1  one-cycle pulse: set request resolved.
- set_err  output  1  valid with set_ack: 1 = rejected, date unchanged.
- carry_mon  output  1  one-cycle pulse: month rolled over on last tick.
- carry_year  output  1  one-cycle pulse: year rolled over on last tick.

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - day=RST_DAY, mon=RST_MON, year=RST_YEAR.
  - set_ack=0, set_err=0, carry_mon=0, carry_year=0.
  - state=RUN; pending registers and tick_pend cleared.
  - rst overrides every other input in the same cycle, including an in-flight CHECK.
- FSM, two states: RUN and CHECK.
- q_mon/q_year (combinational from registered state):
  - RUN: q_mon=mon, q_year=year.
  - CHECK: q_mon=pend_mon, q_year=pend_year.
  - `nod` is treated as combinational on q_*, valid in the same cycle.
- RUN, tick=1:
  - If day+1 < nod: day <= day+1.
  - Else day <= 1, and:
    - mon < 12: mon <= mon+1, carry_mon <= 1.
    - mon = 12: mon <= 1, carry_mon <= 1, carry_year <= 1.
  - On year rollover: year == MAX_YEAR gives year <= 0, otherwise year <= year+1.
- RUN, set_req=1:
  - Capture set_* into pend_day/pend_mon/pend_year; next state CHECK.
  - A tick in the same cycle is applied to the current date; the commit then overwrites it (the tick is lost).
- CHECK, one cycle:
  - Valid iff 1 <= pend_mon <= 12, pend_day >= 1, pend_day < nod, and pend_year <= MAX_YEAR.
  - Valid: day/mon/year <= pend values, set_ack <= 1, set_err <= 0.
  - Invalid: date held, set_ack <= 1, set_err <= 1.
  - Next state RUN unconditionally.
  - For pend_mon outside 1..12, `nod` is 32 (default) and the month check alone rejects.
- tick during CHECK:
  - Latched into tick_pend; the date is not advanced in CHECK.
  - Applied in the first RUN cycle, as a tick on the then-current (possibly just-committed) date.
  - A new tick in that same cycle merges: at most one advance.
- set_req during CHECK: ignored, with no ack.
- Pulse outputs (set_ack, carry_mon, carry_year) are high exactly one cycle, then 0.
- Latency:
  - tick to updated date: 1 cycle.
  - set_req to set_ack and committed date: 2 cycles.
- day/mon/year never take an invalid value after reset, provided the RST_* parameters are valid.

Test Plan:
- Reset: assert rst for 2 cycles mid-CHECK -> day=1, mon=1, year=2000; set_ack=0; state RUN; q_mon=1, q_year=2000.
- Month and leap rollover:
  - From 31/01/2023, one tick -> 01/02/2023, carry_mon=1 for one cycle.
  - From 28/02/2023, one tick -> 01/03/2023.
  - From 28/02/2024, one tick -> 29/02/2024; a further tick -> 01/03/2024.
- Year and top wrap:
  - From 31/12/2023, one tick -> 01/01/2024, carry_mon=carry_year=1.
  - From 31/12/9999, one tick -> 01/01/0000.
- Set validation:
  - set 29/02/2000 -> ack, err=0, committed.
  - set 29/02/1900 -> ack, err=1, date unchanged.
  - set 31/04/2024 -> err=1.
  - set 15/13/2024 -> err=1.
  - set 00/05/2024 -> err=1.
- Simultaneity:
  - tick with set_req 10/06/2024 from 05/03/2024 -> final date 10/06/2024.
  - tick in CHECK -> 11/06/2024 one cycle after set_ack.
  - set_req in CHECK -> no second ack.
- Random ticks, 2000 cycles, against a calendar reference model -> day/mon/year always match; carry pulses coincide with model rollovers.
